// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame layout: LEN_LO, LEN_HI (word count), then words sent least-significant byte first.
package imem_boot_ctrl_pkg;

  localparam int unsigned IMEM_ADDR_W = 13;
  localparam int unsigned LEN_W       = 16;

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RUN   = 3'd4
  } boot_state_e;

  // A frame may fill the memory exactly but never exceed it.
  function automatic logic len_too_big(input logic [LEN_W-1:0] len, input int unsigned addr_w);
    return ({1'b0, len} > (17'd1 << addr_w));
  endfunction

endpackage

// File: rtl/imem_boot_if.sv
// Bundle of loader-side signals: UART byte stream in, fetch PC in, memory write port and core reset out.
interface imem_boot_if #(
  parameter int unsigned ADDR_W = 13
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              cpu_nrst;
  logic              load_err;

  modport master (
    output rx_valid, rx_data, reload, fetch_pc,
    input  rx_ready, mem_addr, mem_we, mem_wdata, cpu_nrst, load_err
  );

  modport slave (
    input  rx_valid, rx_data, reload, fetch_pc,
    output rx_ready, mem_addr, mem_we, mem_wdata, cpu_nrst, load_err
  );

endinterface

// File: rtl/imem_boot_ctrl_word_asm.sv
// Byte-to-word assembler: places each accepted byte into the next lane of a 32-bit word, LSB first.
module imem_word_asm (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;

  // Next lane pointer and word contents.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clr) begin
      byte_cnt_d = 2'd0;
    end else if (byte_en) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    word_d[7:0]   = byte_in;
        2'd1:    word_d[15:8]  = byte_in;
        2'd2:    word_d[23:16] = byte_in;
        2'd3:    word_d[31:24] = byte_in;
        default: word_d        = word_q;
      endcase
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  // Lane pointer and word register.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  assign word      = word_q;
  assign word_done = byte_en && !clr && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/reload sequencer: loads a length-prefixed word stream into instruction memory while holding
// the core in reset, then hands the memory address over to the fetch PC.
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = IMEM_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned SKIP_LOAD   = 0
) (
  input  logic         CLK,
  input  logic         NRST,
  imem_boot_if.slave   bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam boot_state_e RST_STATE = (SKIP_LOAD != 0) ? S_RUN : S_LEN0;
  localparam logic RST_CPU_NRST = (SKIP_LOAD != 0);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              cpu_nrst_q, cpu_nrst_d;
  logic              load_err_q, load_err_d;

  logic        rx_ready_s;
  logic        accept_s;
  logic        byte_en_s;
  logic        asm_clr_s;
  logic        word_done_s;
  logic [31:0] word_s;
  logic [LEN_W-1:0] len_full_s;

  assign rx_ready_s = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
  assign accept_s   = bus.rx_valid && rx_ready_s;
  assign byte_en_s  = accept_s && (state_q == S_DATA);
  assign len_full_s = {bus.rx_data, len_q[7:0]};

  imem_word_asm u_word_asm (
    .CLK       (CLK),
    .NRST      (NRST),
    .clr       (asm_clr_s),
    .byte_en   (byte_en_s),
    .byte_in   (bus.rx_data),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // Next-state, counters and idle timeout; an accepted byte always beats timeout expiry.
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    tmo_d      = {TMO_W{1'b0}};
    cpu_nrst_d = cpu_nrst_q;
    load_err_d = load_err_q;
    asm_clr_s  = 1'b0;
    case (state_q)
      S_LEN0: begin
        if (accept_s) begin
          len_d[7:0] = bus.rx_data;
          load_err_d = 1'b0;
          state_d    = S_LEN1;
        end else begin
          state_d = S_LEN0;
        end
      end
      S_LEN1: begin
        if (accept_s) begin
          len_d = len_full_s;
          if (len_full_s == {LEN_W{1'b0}}) begin
            state_d    = S_RUN;
            cpu_nrst_d = 1'b1;
          end else if (len_too_big(len_full_s, ADDR_W)) begin
            load_err_d = 1'b1;
            state_d    = S_LEN0;
          end else begin
            state_d    = S_DATA;
            waddr_d    = {ADDR_W{1'b0}};
            word_cnt_d = {LEN_W{1'b0}};
            asm_clr_s  = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          load_err_d = 1'b1;
          state_d    = S_LEN0;
          waddr_d    = {ADDR_W{1'b0}};
          word_cnt_d = {LEN_W{1'b0}};
          asm_clr_s  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1'b1);
        end
      end
      S_DATA: begin
        if (accept_s) begin
          state_d = word_done_s ? S_WRITE : S_DATA;
        end else if (tmo_q == TMO_LAST) begin
          load_err_d = 1'b1;
          state_d    = S_LEN0;
          waddr_d    = {ADDR_W{1'b0}};
          word_cnt_d = {LEN_W{1'b0}};
          asm_clr_s  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1'b1);
        end
      end
      S_WRITE: begin
        waddr_d    = waddr_q + ADDR_W'(1'b1);
        word_cnt_d = word_cnt_q + 16'd1;
        if ((word_cnt_q + 16'd1) == len_q) begin
          state_d    = S_RUN;
          cpu_nrst_d = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_RUN: begin
        if (bus.reload) begin
          state_d    = S_LEN0;
          cpu_nrst_d = 1'b0;
          waddr_d    = {ADDR_W{1'b0}};
          word_cnt_d = {LEN_W{1'b0}};
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d    = S_LEN0;
        cpu_nrst_d = 1'b0;
        waddr_d    = {ADDR_W{1'b0}};
        word_cnt_d = {LEN_W{1'b0}};
        asm_clr_s  = 1'b1;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q    <= RST_STATE;
      waddr_q    <= {ADDR_W{1'b0}};
      word_cnt_q <= {LEN_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      cpu_nrst_q <= RST_CPU_NRST;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      cpu_nrst_q <= cpu_nrst_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.rx_ready  = rx_ready_s;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = (state_q == S_RUN) ? bus.fetch_pc : waddr_q;
  assign bus.mem_wdata = word_s;
  assign bus.cpu_nrst  = cpu_nrst_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized frame stream against a byte-position reference model of the boot loader.
module tb_imem_boot_ctrl;

  localparam int AW  = 13;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  imem_boot_if #(.ADDR_W(AW)) bus  ();
  imem_boot_if #(.ADDR_W(AW)) bus2 ();

  imem_boot_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TMO), .SKIP_LOAD(0)) dut (
    .CLK (clk), .NRST (nrst), .bus (bus)
  );
  imem_boot_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TMO), .SKIP_LOAD(1)) dut_skip (
    .CLK (clk), .NRST (nrst), .bus (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_we  = 0;
  logic [7:0]  q[$];
  logic [31:0] dut_mem [0:(1<<AW)-1];

  // Reference model: frame byte position, word count, pending write, error, idle count.
  bit          m_run, m_pend, m_err;
  int          m_pos, m_len, m_words, m_idle;
  logic [31:0] m_word;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    m_pos = 0; m_len = 0; m_words = 0; m_idle = 0; m_word = 32'd0;
  endtask

  task automatic m_step(output bit acc);
    int k;
    acc = 1'b0;
    if (!nrst) begin
      m_reset();
      return;
    end
    if (m_run) begin
      if (bus.reload) begin
        m_run = 1'b0; m_pos = 0; m_words = 0;
      end
    end else if (m_pend) begin
      m_pend = 1'b0;
      m_words++;
      if (m_words == m_len) m_run = 1'b1;
    end else if (bus.rx_valid) begin
      acc = 1'b1;
      m_idle = 0;
      if (m_pos == 0) begin
        m_len = int'(bus.rx_data); m_err = 1'b0; m_pos = 1;
      end else if (m_pos == 1) begin
        m_len = m_len + 256 * int'(bus.rx_data);
        if (m_len == 0) m_run = 1'b1;
        else if (m_len > (1 << AW)) begin m_err = 1'b1; m_pos = 0; end
        else begin m_pos = 2; m_words = 0; end
      end else begin
        k = (m_pos - 2) % 4;
        m_word[8*k +: 8] = bus.rx_data;
        m_pos++;
        if (k == 3) m_pend = 1'b1;
      end
    end else if (m_pos > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_err = 1'b1; m_pos = 0; m_words = 0; m_idle = 0;
      end
    end
  endtask

  task automatic drive();
    bus.fetch_pc = 13'($urandom);
    bus.reload   = m_run ? 1'b0 : 1'($urandom_range(15) == 0);
    if (q.size() > 0) begin
      bus.rx_valid = m_pend ? 1'b1 : 1'($urandom_range(3) != 0);
      bus.rx_data  = q[0];
    end else begin
      bus.rx_valid = m_run ? 1'($urandom_range(1)) : 1'b0;
      bus.rx_data  = 8'($urandom);
    end
  endtask

  task automatic cycle(output bit acc);
    #1;
    check_val("rx_ready", 32'(bus.rx_ready), 32'(!m_run && !m_pend));
    check_val("mem_we",   32'(bus.mem_we),   32'(m_pend));
    check_val("mem_addr", 32'(bus.mem_addr), m_run ? 32'(bus.fetch_pc) : 32'(m_words));
    if (m_pend) check_val("mem_wdata", bus.mem_wdata, m_word);
    check_val("cpu_nrst", 32'(bus.cpu_nrst), 32'(m_run));
    check_val("load_err", 32'(bus.load_err), 32'(m_err));
    if (bus.mem_we === 1'b1) begin
      dut_mem[bus.mem_addr] = bus.mem_wdata;
      n_we++;
    end
    @(posedge clk);
    m_step(acc);
    @(negedge clk);
  endtask

  task automatic drain(input int rst_after);
    bit acc;
    bit done;
    int cyc;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 3000) begin
      drive();
      if (rst_after >= 0 && m_pos == 2 + rst_after && !m_pend && !m_run) nrst = 1'b0;
      cycle(acc);
      if (!nrst) begin
        nrst = 1'b1;
        q.delete();
        rst_after = -1;
      end else if (acc && q.size() > 0) begin
        void'(q.pop_front());
      end
      cyc++;
      done = (q.size() == 0) && (m_run || (m_pos == 0 && !m_pend));
    end
    check_val("drain_done", 32'(done), 32'd1);
  endtask

  task automatic run_phase();
    bit acc;
    repeat (6) begin drive(); cycle(acc); end
    drive(); bus.reload = 1'b1; cycle(acc);
    drive(); cycle(acc);
  endtask

  task automatic build(input int len, input int nbytes);
    q.push_back(8'(len));
    q.push_back(8'(len >> 8));
    for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    int we0;
    int len;
    int kind;
    nrst = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.reload = 1'b0; bus.fetch_pc = 13'h0000;
    bus2.rx_valid = 1'b1; bus2.rx_data = 8'h5a; bus2.reload = 1'b0; bus2.fetch_pc = 13'h1abc;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_wdata",  bus.mem_wdata, 32'h0);
    check_val("rst_cpu",    32'(bus.cpu_nrst), 32'd0);
    check_val("rst_ready",  32'(bus.rx_ready), 32'd1);
    check_val("rst_err",    32'(bus.load_err), 32'd0);
    check_val("skip_cpu",   32'(bus2.cpu_nrst), 32'd1);
    check_val("skip_ready", 32'(bus2.rx_ready), 32'd0);
    check_val("skip_addr",  32'(bus2.mem_addr), 32'h1abc);
    nrst = 1'b1;

    // Two-word frame from the datasheet example.
    we0 = n_we;
    q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    drain(-1);
    check_val("f0_nwe",  32'(n_we - we0), 32'd2);
    check_val("f0_mem0", dut_mem[0], 32'h12345678);
    check_val("f0_mem1", dut_mem[1], 32'hDEADBEEF);
    check_val("f0_cpu",  32'(bus.cpu_nrst), 32'd1);
    run_phase();

    // Empty frame goes straight to RUN.
    we0 = n_we;
    q = '{8'h00, 8'h00};
    drain(-1);
    check_val("len0_nwe", 32'(n_we - we0), 32'd0);
    check_val("len0_cpu", 32'(bus.cpu_nrst), 32'd1);
    run_phase();

    // Oversize header 0x2101.
    we0 = n_we;
    q = '{8'h01, 8'h21};
    drain(-1);
    check_val("big_err", 32'(bus.load_err), 32'd1);
    check_val("big_nwe", 32'(n_we - we0), 32'd0);

    // Two data bytes then silence until timeout.
    we0 = n_we;
    q = '{8'h03, 8'h00, 8'h11, 8'h22};
    drain(-1);
    check_val("tmo_err", 32'(bus.load_err), 32'd1);
    check_val("tmo_nwe", 32'(n_we - we0), 32'd0);

    // Reset after the third data byte.
    build(2, 8);
    drain(3);
    check_val("rst_mid_cpu",   32'(bus.cpu_nrst), 32'd0);
    check_val("rst_mid_ready", 32'(bus.rx_ready), 32'd1);
    check_val("rst_mid_err",   32'(bus.load_err), 32'd0);

    // Exactly full memory is accepted; truncate after three words.
    we0 = n_we;
    build(8192, 12);
    drain(-1);
    check_val("full_nwe", 32'(n_we - we0), 32'd3);
    check_val("full_err", 32'(bus.load_err), 32'd1);

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(9);
      case (kind)
        0, 1, 2, 3, 4, 5: begin len = $urandom_range(6, 1); build(len, 4 * len); drain(-1); end
        6: begin len = $urandom_range(6, 2); build(len, $urandom_range(4 * len - 1, 0)); drain(-1); end
        7: begin len = $urandom_range(6, 1); build(len, 4 * len); drain($urandom_range(4 * len - 1, 0)); end
        8: begin len = $urandom_range(65535, 8193); build(len, 0); drain(-1); end
        default: begin build(0, 0); drain(-1); end
      endcase
      if (m_run) run_phase();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
